// File: rtl/opb_ctl_reg_bank.sv
// opb_ctl_reg_bank
//   OPB slave owning C_NUM_REGS 32-bit control registers behind one address
//   window. Software writes shadow registers. A commit write to CTRL copies
//   every shadow to the active outputs in one edge and pulses user_update, so
//   the datapath sees multi-register reconfiguration atomically.
//
//   Word map (word = (OPB_ABus - C_BASEADDR) >> 2):
//     0 .. C_NUM_REGS-1 : shadow registers, R/W, byte enables honoured
//     C_NUM_REGS        : CTRL. Writing bit 0 (with its byte enabled) commits.
//                         Reads return {commit_count[15:0], 16'h0}.
//     C_NUM_REGS+1      : STATUS, read-only. Returns user_status_in.
//     above             : invalid. Reads return 0 and writes are dropped.
//
//   Ports:
//     OPB_Clk, OPB_Rst          clock, asynchronous active-high reset
//     OPB_ABus/BE/DBus/RNW      OPB request (big-endian bit numbering)
//     OPB_select, OPB_seqAddr   transaction valid; seqAddr is ignored
//     Sl_DBus, Sl_xferAck       read data and acknowledge (one cycle)
//     Sl_errAck                 error acknowledge
//     Sl_retry, Sl_toutSup      tied 0
//     user_data_out             active registers, reg k at [32k+31:32k]
//     user_update               one-cycle pulse after each commit
//     user_status_in            status word readable by software
//
//   Optional feature macro: OPB_CTL_REG_ERRACK_EN
//     When defined, an access to an invalid word or a write to STATUS raises
//     Sl_errAck together with Sl_xferAck. When undefined, Sl_errAck is 0.
module opb_ctl_reg_bank #(
  parameter logic [31:0] C_BASEADDR   = 32'h01060000,
  parameter logic [31:0] C_HIGHADDR   = 32'h010600FF,
  parameter int          C_NUM_REGS   = 4,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32
) (
  input  logic                           OPB_Clk,
  input  logic                           OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]        OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1]      OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]        OPB_DBus,
  input  logic                           OPB_RNW,
  input  logic                           OPB_select,
  input  logic                           OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]        Sl_DBus,
  output logic                           Sl_errAck,
  output logic                           Sl_retry,
  output logic                           Sl_toutSup,
  output logic                           Sl_xferAck,
  output logic [C_NUM_REGS*32-1:0]       user_data_out,
  output logic                           user_update,
  input  logic [31:0]                    user_status_in
);

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT} state_t;

  state_t      state, state_nxt;
  logic [31:0] shadow [C_NUM_REGS];
  logic [31:0] active [C_NUM_REGS];
  logic [15:0] commit_count;
  logic [31:0] rd_q;
  logic        ack_q;
  logic        upd_q;

  // Plain [31:0] views: OPB bit 0 is the MSB, so a straight vector copy maps
  // DBus[0] to register bit 31 and BE[0] to be[3] (bits 31:24).
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] off;
  logic [31:0] word;
  logic        hit, take, wr, commit;
  logic        is_ctrl, is_stat;
  logic [31:0] rmux;
  logic        unused_ok;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  en);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = en[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return r;
  endfunction

  assign addr    = OPB_ABus;
  assign wdata   = OPB_DBus;
  assign be      = OPB_BE;
  assign off     = addr - C_BASEADDR;
  assign word    = {2'b00, off[31:2]};
  assign hit     = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  assign is_ctrl = (word == 32'(C_NUM_REGS));
  assign is_stat = (word == 32'(C_NUM_REGS + 1));

  // Only the IDLE state accepts a request; WAIT swallows a stretched select.
  assign take   = (state == S_IDLE) && hit;
  assign wr     = take && !OPB_RNW;
  assign commit = wr && is_ctrl && be[0] && wdata[0];

  assign unused_ok = ^{OPB_seqAddr, off[1:0]};

  always_comb begin
    rmux = 32'h0;
    for (int k = 0; k < C_NUM_REGS; k++)
      if (word == 32'(k)) rmux = shadow[k];
    if (is_ctrl) rmux = {commit_count, 16'h0};
    if (is_stat) rmux = user_status_in;
  end

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (hit) state_nxt = S_ACK;
      S_ACK:   state_nxt = S_WAIT;
      S_WAIT:  if (!OPB_select) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request edge: register ack/read data, apply writes and commits
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      ack_q        <= 1'b0;
      rd_q         <= 32'h0;
      upd_q        <= 1'b0;
      commit_count <= 16'h0;
      for (int k = 0; k < C_NUM_REGS; k++) begin
        shadow[k] <= 32'h0;
        active[k] <= 32'h0;
      end
    end else begin
      ack_q <= take;
      // Read data lives only in the ACK cycle, zero otherwise.
      rd_q  <= (take && OPB_RNW) ? rmux : 32'h0;
      upd_q <= commit;
      for (int k = 0; k < C_NUM_REGS; k++)
        if (wr && (word == 32'(k)))
          shadow[k] <= byte_merge(shadow[k], wdata, be);
      if (commit) begin
        commit_count <= commit_count + 16'h1;
        for (int k = 0; k < C_NUM_REGS; k++)
          active[k] <= shadow[k];
      end
    end
  end

`ifdef OPB_CTL_REG_ERRACK_EN
  logic err_q;
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) err_q <= 1'b0;
    else         err_q <= take && ((word > 32'(C_NUM_REGS + 1)) ||
                                   (is_stat && !OPB_RNW));
  end
  assign Sl_errAck = err_q;
`else
  assign Sl_errAck = 1'b0;
`endif

  always_comb begin
    user_data_out = '0;
    for (int k = 0; k < C_NUM_REGS; k++)
      user_data_out[32*k +: 32] = active[k];
  end

  assign Sl_DBus     = rd_q;
  assign Sl_xferAck  = ack_q;
  assign user_update = upd_q;
  assign Sl_retry    = 1'b0;
  assign Sl_toutSup  = 1'b0;

endmodule

// File: tb/tb_opb_ctl_reg_bank.sv
module tb_opb_ctl_reg_bank;

  localparam logic [31:0] BASE = 32'h01060000;

  logic         clk;
  logic         rst;
  logic [0:31]  abus;
  logic [0:3]   be;
  logic [0:31]  dbus;
  logic         rnw;
  logic         sel;
  logic         seq;
  logic [0:31]  sl_dbus;
  logic         sl_err;
  logic         sl_retry;
  logic         sl_tout;
  logic         sl_ack;
  logic [127:0] udata;
  logic         uupd;
  logic [31:0]  ustat;

  int total = 0;
  int bad   = 0;

  logic [31:0] rd;
  logic        err, upd, upd2;
  int          acks;
  logic        exp_err;

  opb_ctl_reg_bank dut (
    .OPB_Clk        (clk),
    .OPB_Rst        (rst),
    .OPB_ABus       (abus),
    .OPB_BE         (be),
    .OPB_DBus       (dbus),
    .OPB_RNW        (rnw),
    .OPB_select     (sel),
    .OPB_seqAddr    (seq),
    .Sl_DBus        (sl_dbus),
    .Sl_errAck      (sl_err),
    .Sl_retry       (sl_retry),
    .Sl_toutSup     (sl_tout),
    .Sl_xferAck     (sl_ack),
    .user_data_out  (udata),
    .user_update    (uupd),
    .user_status_in (ustat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One OPB transaction. Select is held for 'hold' cycles after the ack cycle.
  task automatic acc(input logic [31:0] a, input logic r, input logic [3:0] b,
                     input logic [31:0] d, input int hold,
                     output logic [31:0] rdv, output logic errv,
                     output logic updv, output logic upd2v, output int nack);
    @(posedge clk); #1;
    abus = a; rnw = r; be = b; dbus = r ? 32'h0 : d; sel = 1'b1;
    chk("ack_early", {127'h0, sl_ack}, 128'h0);
    @(posedge clk); #1;
    rdv  = sl_dbus;
    errv = sl_err;
    updv = uupd;
    nack = sl_ack ? 1 : 0;
    chk("ack_latency", {127'h0, sl_ack}, 128'h1);
    upd2v = 1'b0;
    for (int i = 0; i < hold; i++) begin
      if (i == hold - 1) sel = 1'b0;
      @(posedge clk); #1;
      if (sl_ack) nack++;
      if (i == 0) upd2v = uupd;
    end
    chk("dbus_after_ack", {96'h0, sl_dbus}, 128'h0);
  endtask

  initial begin
    rst = 1'b1; abus = '0; be = '0; dbus = '0; rnw = 1'b1; sel = 1'b0; seq = 1'b0;
    ustat = 32'h0;
`ifdef OPB_CTL_REG_ERRACK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack",    {127'h0, sl_ack}, 128'h0);
    chk("rst_dbus",   {96'h0, sl_dbus}, 128'h0);
    chk("rst_err",    {127'h0, sl_err}, 128'h0);
    chk("rst_update", {127'h0, uupd},   128'h0);
    chk("rst_udata",  udata,            128'h0);
    chk("retry_tout", {126'h0, sl_retry, sl_tout}, 128'h0);
    rst = 1'b0;

    // Every word reads zero after reset (STATUS input is 0 here).
    for (int w = 0; w < 6; w++) begin
      acc(BASE + 32'(4*w), 1'b1, 4'hF, 32'h0, 1, rd, err, upd, upd2, acks);
      chk($sformatf("rst_read_w%0d", w), {96'h0, rd}, 128'h0);
    end
    chk("rst_udata_after_reads", udata, 128'h0);

    // Shadow write does not reach the outputs before a commit.
    acc(BASE, 1'b0, 4'hF, 32'hDEADBEEF, 1, rd, err, upd, upd2, acks);
    chk("sh0_wr_update", {127'h0, upd}, 128'h0);
    chk("sh0_wr_udata",  udata, 128'h0);
    acc(BASE, 1'b1, 4'hF, 32'h0, 1, rd, err, upd, upd2, acks);
    chk("sh0_readback", {96'h0, rd}, {96'h0, 32'hDEADBEEF});

    // Commit.
    acc(BASE + 32'h10, 1'b0, 4'hF, 32'h00000001, 1, rd, err, upd, upd2, acks);
    chk("commit1_update",      {127'h0, upd},  128'h1);
    chk("commit1_update_drop", {127'h0, upd2}, 128'h0);
    chk("commit1_udata", udata, {96'h0, 32'hDEADBEEF});
    acc(BASE + 32'h10, 1'b1, 4'hF, 32'h0, 1, rd, err, upd, upd2, acks);
    chk("ctrl_count1", {96'h0, rd}, {96'h0, 32'h00010000});

    // Byte enables 0101 over a zero register.
    acc(BASE + 32'h4, 1'b0, 4'b0101, 32'h11223344, 1, rd, err, upd, upd2, acks);
    acc(BASE + 32'h4, 1'b1, 4'hF, 32'h0, 1, rd, err, upd, upd2, acks);
    chk("sh1_byte_en", {96'h0, rd}, {96'h0, 32'h00220044});

    // Stretched select on a STATUS read: one ack only.
    ustat = 32'hCAFE0001;
    acc(BASE + 32'h14, 1'b1, 4'hF, 32'h0, 6, rd, err, upd, upd2, acks);
    chk("stretch_acks", 128'(acks), 128'd1);
    chk("status_read",  {96'h0, rd}, {96'h0, 32'hCAFE0001});

    // Invalid word read and write.
    acc(BASE + 32'h18, 1'b1, 4'hF, 32'h0, 1, rd, err, upd, upd2, acks);
    chk("invalid_rd_data", {96'h0, rd}, 128'h0);
    chk("invalid_rd_err",  {127'h0, err}, {127'h0, exp_err});
    acc(BASE + 32'h18, 1'b0, 4'hF, 32'hFFFFFFFF, 1, rd, err, upd, upd2, acks);
    chk("invalid_wr_err",  {127'h0, err}, {127'h0, exp_err});
    acc(BASE + 32'h14, 1'b0, 4'hF, 32'h12345678, 1, rd, err, upd, upd2, acks);
    chk("status_wr_err",   {127'h0, err}, {127'h0, exp_err});
    acc(BASE, 1'b1, 4'hF, 32'h0, 1, rd, err, upd, upd2, acks);
    chk("sh0_unchanged",   {96'h0, rd}, {96'h0, 32'hDEADBEEF});
    chk("valid_read_err",  {127'h0, err}, 128'h0);

    // Non-committing CTRL writes: bit 0 clear, or its byte disabled.
    acc(BASE, 1'b0, 4'hF, 32'h12345678, 1, rd, err, upd, upd2, acks);
    acc(BASE + 32'h10, 1'b0, 4'hF, 32'h00000002, 1, rd, err, upd, upd2, acks);
    chk("ctrl_bit0_clear_upd", {127'h0, upd}, 128'h0);
    acc(BASE + 32'h10, 1'b0, 4'b1110, 32'h00000001, 1, rd, err, upd, upd2, acks);
    chk("ctrl_be3_clear_upd", {127'h0, upd}, 128'h0);
    chk("no_commit_udata", udata, {96'h0, 32'hDEADBEEF});

    // Second commit picks up both shadows at once.
    acc(BASE + 32'h10, 1'b0, 4'hF, 32'h00000001, 1, rd, err, upd, upd2, acks);
    chk("commit2_update", {127'h0, upd}, 128'h1);
    chk("commit2_udata", udata, {64'h0, 32'h00220044, 32'h12345678});
    acc(BASE + 32'h10, 1'b1, 4'hF, 32'h0, 1, rd, err, upd, upd2, acks);
    chk("ctrl_count2", {96'h0, rd}, {96'h0, 32'h00020000});

    // Commit with unchanged shadows still pulses and counts.
    acc(BASE + 32'h10, 1'b0, 4'h1, 32'h00000001, 1, rd, err, upd, upd2, acks);
    chk("commit3_update", {127'h0, upd}, 128'h1);
    acc(BASE + 32'h10, 1'b1, 4'hF, 32'h0, 1, rd, err, upd, upd2, acks);
    chk("ctrl_count3", {96'h0, rd}, {96'h0, 32'h00030000});

    // Reset asserted in the ACK cycle.
    @(posedge clk); #1;
    abus = BASE; rnw = 1'b1; be = 4'hF; sel = 1'b1;
    @(posedge clk); #1;
    chk("pre_reset_ack",  {127'h0, sl_ack}, 128'h1);
    chk("pre_reset_data", {96'h0, sl_dbus}, {96'h0, 32'h12345678});
    rst = 1'b1; sel = 1'b0;
    #1;
    chk("midrst_ack",   {127'h0, sl_ack}, 128'h0);
    chk("midrst_dbus",  {96'h0, sl_dbus}, 128'h0);
    chk("midrst_udata", udata, 128'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    acks = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (sl_ack) acks++;
    end
    chk("post_reset_no_ack", 128'(acks), 128'd0);
    acc(BASE, 1'b1, 4'hF, 32'h0, 1, rd, err, upd, upd2, acks);
    chk("post_reset_sh0", {96'h0, rd}, 128'h0);
    acc(BASE + 32'h10, 1'b1, 4'hF, 32'h0, 1, rd, err, upd, upd2, acks);
    chk("post_reset_count", {96'h0, rd}, 128'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/opb_ctl_reg_bank.md
Name: opb_ctl_reg_bank

Overview:
- OPB slave owning a bank of C_NUM_REGS 32-bit control registers (e.g. ant_base, fft_shift, eq controls) behind one address window.
- Software writes to shadow registers; a write to the commit register copies all shadows to the active outputs together and pulses user_update.
- Gives the F-engine datapath atomic multi-register reconfiguration without per-register glitches.
- Sits on the PPC OPB bus beside the single-register ppc2simulink slaves; all logic runs on the OPB clock.

Parameters:
- C_BASEADDR, 32'h01060000, first byte address of the window
- C_HIGHADDR, 32'h010600FF, last byte address of the window
- C_NUM_REGS, 4, number of shadow/active register pairs (1..32)
- C_OPB_AWIDTH, 32, OPB address width
- C_OPB_DWIDTH, 32, OPB data width

Ports:
- OPB_Clk  in  1  sole clock
- OPB_Rst  in  1  asynchronous, active-high reset
- OPB_ABus  in  [0:31]  byte address, bit 0 MSB
- OPB_BE  in  [0:3]  byte enables; BE[0] covers DBus[0:7] = register bits 31:24
- OPB_DBus  in  [0:31]  write data
- OPB_RNW  in  1  1 = read, 0 = write
- OPB_select  in  1  transaction valid
- OPB_seqAddr  in  1  ignored
- Sl_DBus  out  [0:31]  read data; zero except in the ack cycle
- Sl_errAck  out  1  error acknowledge
- Sl_retry  out  1  tied 0
- Sl_toutSup  out  1  tied 0
- Sl_xferAck  out  1  transfer acknowledge
- user_data_out  out  [C_NUM_REGS*32-1:0]  active registers; reg k at bits [32k+31:32k]
- user_update  out  1  one-cycle pulse when the active registers change
- user_status_in  in  [31:0]  status word, readable by software

Behaviour:
- Clock and reset: one clock, OPB_Clk; reset OPB_Rst is asynchronous and active-high.
- Reset values:
  - all shadow and active registers 0; commit_count 0
  - Sl_DBus, Sl_xferAck, Sl_errAck, user_update all 0
  - FSM in IDLE
- Decode: hit = OPB_select && C_BASEADDR <= OPB_ABus <= C_HIGHADDR. Word index w = (OPB_ABus - C_BASEADDR) >> 2.
- Register map:
  - w < C_NUM_REGS: shadow reg w, R/W.
  - w = C_NUM_REGS: CTRL.
    - Write with BE[3]=1 and DBus[31]=1 (register bit 0) commits.
    - Read returns {commit_count[15:0], 16'h0}.
  - w = C_NUM_REGS+1: STATUS, read-only. Returns user_status_in sampled in the IDLE->ACK cycle. Writes ignored.
  - Any larger w: invalid. Reads return 0; writes are ignored.
- Writes: byte-granular per OPB_BE. Bytes with BE clear keep their old value.
- FSM:
  - IDLE -> ACK on hit. Read data is registered on this transition. A write is applied in the same edge.
  - ACK: Sl_xferAck=1 for exactly one cycle; Sl_DBus carries read data (0 for writes). ACK -> WAIT unconditionally.
  - WAIT: held while OPB_select=1, which prevents a double ack on a stretched select. WAIT -> IDLE when OPB_select=0.
- Latency: select sampled at edge N; xferAck high in cycle N+1.
- Commit:
  - On the CTRL-write edge, all shadows are copied to the active registers, including a shadow written in the same transaction? No: only one access per transaction, so shadows are stable.
  - user_update is 1 in the following cycle, for 1 cycle.
  - commit_count increments and wraps 0xFFFF -> 0x0000.
  - A commit with no shadow change still pulses user_update and increments the count.
- Shadow writes never change user_data_out until a commit.
- Reset mid-transaction: FSM returns to IDLE and no ack is issued; the master times out. Any partially written shadow is cleared to 0.
- OPB_select deasserted early in ACK: the ack is still issued, then WAIT -> IDLE on the next cycle.

Optional Feature:
- Macro: OPB_CTL_REG_ERRACK_EN.
- Defined: an access to an invalid word, or a write to STATUS, asserts Sl_errAck in the same cycle as Sl_xferAck. Sl_DBus is 0 and no state changes.
- Undefined: Sl_errAck is tied 0; such accesses are silently acked (reads 0, writes dropped).

Test Plan:
- Reset, then read all words -> every shadow reads 0x00000000, CTRL reads 0x00000000, user_data_out=0, xferAck exactly 1 cycle after select.
- Write 0xDEADBEEF to shadow 0, BE=4'b1111 -> user_data_out[31:0] stays 0; readback 0xDEADBEEF.
- Write CTRL=0x00000001 -> next cycle user_data_out[31:0]=0xDEADBEEF, user_update one-cycle pulse, CTRL read = 0x00010000.
- Write 0x11223344 to shadow 1 with BE=4'b0101 over 0 -> readback 0x00220044.
- Hold OPB_select high for 6 cycles on a read -> exactly one xferAck; drive user_status_in=0xCAFE0001 -> STATUS read returns it.
- Read word C_NUM_REGS+2 -> Sl_DBus=0, Sl_errAck=1 only with OPB_CTL_REG_ERRACK_EN, otherwise 0.
- Assert OPB_Rst during ACK -> outputs 0 immediately, no further ack.
